frame_trailer_crc: RTL and testbench
====================================

Name: frame_trailer_crc

Overview:
- Sits directly downstream of the frame sequencer FSM.
- Consumes its VALID / CLR_CRC / LAST_WRD strobes plus the sample-FIFO data word.
- Passes the 96 ADC data words of each sample frame through, replaces the 4 tail slots with a formatted trailer (L1A number, sample number, status, CRC-16), and writes the result to the link output FIFO.
- Flags framing and overflow errors.

Parameters:
NDATA, 96, data words per frame; trailer slots are word indices NDATA..NDATA+3
CRC_POLY, 16'h1021, CRC-16 generator polynomial (x^16+x^12+x^5+1), MSB-first, one 16-bit word per clock
CRC_INIT, 16'h0000, CRC register value loaded on CLR_CRC

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
CLR_CRC  in  1  frame-start strobe from sequencer; loads CRC_INIT, zeroes word index
VALID  in  1  word strobe from sequencer; one per frame slot (100 per frame)
LAST_WRD  in  1  end-of-event strobe from sequencer
DIN  in  16  sample FIFO data, aligned with VALID
L1A_NUM  in  12  L1A number of the event being read, stable for the whole event
SMP  in  7  current sample number, stable during the frame
OFIFO_FULL  in  1  link output FIFO full
CLR_ERR  in  1  synchronous clear of sticky error flags
DOUT  out  16  output word
DOUT_WE  out  1  output FIFO write enable
DOUT_LAST  out  1  high with final trailer word (index NDATA+3)
EVT_DONE  out  1  one-cycle pulse: event complete
CRC  out  16  CRC register, valid after each frame
OVFL  out  1  sticky: write attempted while OFIFO_FULL
FRM_ERR  out  1  sticky: framing error
WCNT  out  7  word index of next expected slot

Behaviour:
- Reset values: all outputs 0; CRC = CRC_INIT; state IDLE.
- All outputs are registered. Latency is 1 cycle: DOUT/DOUT_WE appear the cycle after the VALID they belong to.
- States:
  - IDLE: on CLR_CRC, go to DATA.
  - DATA: while VALID and WCNT<NDATA, DOUT=DIN and WCNT++. Leaving word NDATA-1 goes to TRAIL.
  - TRAIL: on each VALID, emit trailer word WCNT-NDATA:
    - 0 = {4'hD, L1A_NUM}
    - 1 = {4'hE, 5'b0, SMP}
    - 2 = {4'hF, 3'b0, FRM_ERR, OVFL, WCNT_at_trailer_start[6:0]... truncated to 16 bits as {4'hF,4'h0,OVFL,7'd(NDATA)}}
    - 3 = final CRC value, with DOUT_LAST=1.
  - After trailer word 3, go to IDLE.
- CRC update:
  - Covers DATA words and trailer words 0..2.
  - Each covered word updates CRC in the same cycle its DOUT is registered.
  - Trailer word 3 carries the CRC after word 2's update and is not itself folded in.
  - CRC output holds that value until the next CLR_CRC.
- CLR_CRC has priority over VALID in the same cycle: the CRC is reloaded, WCNT=0, and the VALID word is treated as word 0 of the new frame.
- CLR_CRC in DATA or TRAIL (frame aborted): set FRM_ERR, restart as above. No DOUT_LAST for the aborted frame.
- VALID in IDLE (no frame open): word dropped, no DOUT_WE, FRM_ERR set.
- LAST_WRD:
  - EVT_DONE pulses the next cycle.
  - If LAST_WRD arrives while not IDLE, also set FRM_ERR and go to IDLE.
  - LAST_WRD coincident with CLR_CRC: CLR_CRC wins, FRM_ERR set.
- OFIFO_FULL while DOUT_WE would assert: the write is still issued (no backpressure to sequencer), OVFL set.
- CLR_ERR clears OVFL/FRM_ERR the next cycle. An error event in the same cycle wins (flag stays 1).
- Async RST mid-frame: immediate return to IDLE, all outputs 0 at once. The partial frame is discarded; the next frame starts only on CLR_CRC.

Test Plan:
- Nominal frame, DIN=0 for all 96 words, L1A_NUM=12'h123, SMP=7'd5, CRC_INIT=0 -> 100 DOUT_WE pulses:
  - words 0..95 = 16'h0000
  - 96 = 16'hD123, 97 = 16'hE005, 98 = 16'hF060
  - 99 = CRC(reference model over 99 words) with DOUT_LAST=1
- Nominal frame with DIN=word index -> DOUT words 0..95 = 0..95 with one-cycle latency; the CRC output and word 99 both match the software CRC-16 model.
- CLR_CRC at word 40 of a frame, then a full frame -> FRM_ERR=1; second frame complete with 100 words, correct CRC; no DOUT_LAST before the second frame's word 99.
- OFIFO_FULL held high for words 10-12 -> all 100 writes still issued; OVFL=1 thereafter, including trailer word 98 bit 7; CLR_ERR -> OVFL=0 next cycle.
- VALID pulses in IDLE; LAST_WRD after a full frame -> stray VALIDs produce no DOUT_WE and set FRM_ERR; EVT_DONE pulses exactly one cycle after LAST_WRD.
- RST asserted at word 97 -> DOUT_WE, DOUT_LAST, WCNT, CRC all 0 immediately; the following VALIDs are ignored until CLR_CRC.

Source files
------------

// File: rtl/frame_trailer_crc.sv
// frame_trailer_crc: passes NDATA data words per frame through and replaces the
// four tail slots with an L1A / sample / status / CRC-16 trailer.
module frame_trailer_crc #(
    parameter int          NDATA    = 96,
    parameter logic [15:0] CRC_POLY = 16'h1021,
    parameter logic [15:0] CRC_INIT = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CLR_CRC,
    input  logic        VALID,
    input  logic        LAST_WRD,
    input  logic [15:0] DIN,
    input  logic [11:0] L1A_NUM,
    input  logic [6:0]  SMP,
    input  logic        OFIFO_FULL,
    input  logic        CLR_ERR,
    output logic [15:0] DOUT,
    output logic        DOUT_WE,
    output logic        DOUT_LAST,
    output logic        EVT_DONE,
    output logic [15:0] CRC,
    output logic        OVFL,
    output logic        FRM_ERR,
    output logic [6:0]  WCNT
);
    typedef enum logic [1:0] {IDLE, DATA, TRAIL} state_t;

    state_t      state_q, state_d, st_b;
    logic [6:0]  wcnt_q, wcnt_d, idx_b;
    logic [15:0] crc_q, crc_d, crc_b, dout_q, dout_d;
    logic        we_q, we_d, last_q, last_d, evt_q, ovfl_q, ovfl_d, ferr_q, ferr_d;
    logic [1:0]  slot;

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 15; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? CRC_POLY : 16'h0000);
        return r;
    endfunction

    always_comb begin
        // CLR_CRC restarts the frame first, so a coincident VALID becomes word 0
        st_b    = CLR_CRC ? DATA : state_q;
        idx_b   = CLR_CRC ? 7'd0 : wcnt_q;
        crc_b   = CLR_CRC ? CRC_INIT : crc_q;
        slot    = 2'(idx_b - 7'(NDATA));
        state_d = st_b;
        wcnt_d  = idx_b;
        crc_d   = crc_b;
        dout_d  = dout_q;
        we_d    = 1'b0;
        last_d  = 1'b0;
        if (VALID && st_b != IDLE) begin
            we_d   = 1'b1;
            wcnt_d = idx_b + 7'd1;
            if (st_b == DATA) begin
                dout_d  = DIN;
                crc_d   = crc_upd(crc_b, DIN);
                state_d = (wcnt_d == 7'(NDATA)) ? TRAIL : DATA;
            end else begin
                dout_d  = (slot == 2'd0) ? {4'hD, L1A_NUM} :
                          (slot == 2'd1) ? {4'hE, 5'b0, SMP} :
                          (slot == 2'd2) ? {4'hF, 4'h0, ovfl_q, 7'(NDATA)} : crc_b;
                crc_d   = (slot == 2'd3) ? crc_b : crc_upd(crc_b, dout_d);
                last_d  = (slot == 2'd3);
                state_d = (slot == 2'd3) ? IDLE : TRAIL;
            end
        end
        if (LAST_WRD && !CLR_CRC) state_d = IDLE;
        ovfl_d = (we_d && OFIFO_FULL) || (ovfl_q && !CLR_ERR);
        ferr_d = (CLR_CRC && state_q != IDLE) || (VALID && st_b == IDLE) ||
                 (LAST_WRD && (CLR_CRC || state_q != IDLE)) || (ferr_q && !CLR_ERR);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            wcnt_q  <= 7'd0;
            crc_q   <= CRC_INIT;
            dout_q  <= 16'h0000;
            we_q    <= 1'b0;
            last_q  <= 1'b0;
            evt_q   <= 1'b0;
            ovfl_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            crc_q   <= crc_d;
            dout_q  <= dout_d;
            we_q    <= we_d;
            last_q  <= last_d;
            evt_q   <= LAST_WRD;
            ovfl_q  <= ovfl_d;
            ferr_q  <= ferr_d;
        end
    end

    assign DOUT      = dout_q;
    assign DOUT_WE   = we_q;
    assign DOUT_LAST = last_q;
    assign EVT_DONE  = evt_q;
    assign CRC       = crc_q;
    assign OVFL      = ovfl_q;
    assign FRM_ERR   = ferr_q;
    assign WCNT      = wcnt_q;
endmodule

// File: tb/tb_frame_trailer_crc.sv
// tb_frame_trailer_crc: scoreboard bench for frame_trailer_crc; expected words are
// queued as each slot is driven and compared as the DUT writes them out.
module tb_frame_trailer_crc;
    logic        clk = 1'b0, rst = 1'b1;
    logic        clr_crc = 1'b0, valid = 1'b0, last_wrd = 1'b0, ofifo_full = 1'b0, clr_err = 1'b0;
    logic [15:0] din = 16'h0000;
    logic [11:0] l1a = 12'h000;
    logic [6:0]  smp = 7'd0;
    logic [15:0] dout, crc_o;
    logic        dout_we, dout_last, evt_done, ovfl, frm_err;
    logic [6:0]  wcnt;

    int          n_tests = 0, n_fail = 0;
    logic [16:0] sb[$];
    logic [16:0] e;
    logic [15:0] m_crc;
    logic        m_ovfl = 1'b0;

    always #5 clk = ~clk;

    frame_trailer_crc dut (
        .CLK(clk), .RST(rst), .CLR_CRC(clr_crc), .VALID(valid), .LAST_WRD(last_wrd),
        .DIN(din), .L1A_NUM(l1a), .SMP(smp), .OFIFO_FULL(ofifo_full), .CLR_ERR(clr_err),
        .DOUT(dout), .DOUT_WE(dout_we), .DOUT_LAST(dout_last), .EVT_DONE(evt_done),
        .CRC(crc_o), .OVFL(ovfl), .FRM_ERR(frm_err), .WCNT(wcnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register-at-once CRC formulation, independent of the bitwise DUT form
    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [15:0] w);
        logic [15:0] r;
        r = c ^ w;
        repeat (16) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && dout_we) begin
            if (sb.size() == 0) chk("spurious_we", 1, 0);
            else begin
                e = sb.pop_front();
                chk("dout", {16'h0, dout}, {16'h0, e[15:0]});
                chk("dout_last", {31'h0, dout_last}, {31'h0, e[16]});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid = 1'b0; clr_crc = 1'b0; ofifo_full = 1'b0; last_wrd = 1'b0; clr_err = 1'b0;
        end
    endtask

    // mode 0: zeros, 1: word index, 2: random; drives slots 0..nw-1
    task automatic frame(input int mode, input int nw, input int flo, input int fhi);
        logic [15:0] c, w, d;
        c = 16'h0000;
        for (int i = 0; i < nw; i++) begin
            @(negedge clk);
            d = (mode == 0) ? 16'h0 : (mode == 1) ? 16'(i) : 16'($urandom);
            w = (i < 96) ? d : (i == 96) ? {4'hD, l1a} : (i == 97) ? {4'hE, 5'b0, smp} :
                (i == 98) ? {4'hF, 4'h0, m_ovfl, 7'd96} : c;
            clr_crc = (i == 0); valid = 1'b1; last_wrd = 1'b0; clr_err = 1'b0;
            ofifo_full = (i >= flo && i <= fhi);
            din = (i < 96) ? d : 16'($urandom);
            sb.push_back({i == 99, w});
            if (i < 99) c = ref_crc(c, w);
            if (ofifo_full) m_ovfl = 1'b1;
        end
        m_crc = c;
    endtask

    task automatic pulse_clr_err();
        @(negedge clk); clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        m_ovfl = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_dout", {16'h0, dout}, 0);
        chk("rst_we_last_evt", {29'h0, dout_we, dout_last, evt_done}, 0);
        chk("rst_crc", {16'h0, crc_o}, 0);
        chk("rst_flags", {30'h0, ovfl, frm_err}, 0);
        chk("rst_wcnt", {25'h0, wcnt}, 0);
        rst = 1'b0;
        idle(2);

        l1a = 12'h123; smp = 7'd5;
        frame(0, 100, -1, -1);
        idle(2);
        chk("crc_zero_frame", {16'h0, crc_o}, {16'h0, m_crc});
        chk("frm_err_clean", {31'h0, frm_err}, 0);

        @(negedge clk); last_wrd = 1'b1;
        chk("evt_before", {31'h0, evt_done}, 0);
        @(negedge clk); last_wrd = 1'b0;
        chk("evt_pulse", {31'h0, evt_done}, 1);
        @(negedge clk);
        chk("evt_one_cycle", {31'h0, evt_done}, 0);
        chk("last_in_idle_no_err", {31'h0, frm_err}, 0);

        l1a = 12'hABC; smp = 7'h33;
        frame(1, 100, -1, -1);
        idle(2);
        chk("crc_index_frame", {16'h0, crc_o}, {16'h0, m_crc});

        repeat (3) begin @(negedge clk); valid = 1'b1; din = 16'($urandom); end
        idle(2);
        chk("stray_valid_err", {31'h0, frm_err}, 1);
        pulse_clr_err();
        chk("frm_err_cleared", {31'h0, frm_err}, 0);

        l1a = 12'h5A5; smp = 7'd100;
        frame(2, 40, -1, -1);
        frame(2, 100, -1, -1);
        idle(2);
        chk("abort_err", {31'h0, frm_err}, 1);
        chk("crc_after_abort", {16'h0, crc_o}, {16'h0, m_crc});
        pulse_clr_err();

        l1a = 12'hFFF; smp = 7'd127;
        frame(2, 100, 10, 12);
        idle(2);
        chk("ovfl_set", {31'h0, ovfl}, 1);
        chk("crc_ovfl_frame", {16'h0, crc_o}, {16'h0, m_crc});
        @(negedge clk); clr_err = 1'b1;
        chk("ovfl_held", {31'h0, ovfl}, 1);
        @(negedge clk); clr_err = 1'b0; m_ovfl = 1'b0;
        chk("ovfl_cleared", {31'h0, ovfl}, 0);

        frame(2, 97, -1, -1);
        @(negedge clk); valid = 1'b1; clr_crc = 1'b0; din = 16'($urandom);
        chk("wcnt_mid", {25'h0, wcnt}, 97);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_we", {30'h0, dout_we, dout_last}, 0);
        chk("rst_mid_wcnt", {25'h0, wcnt}, 0);
        chk("rst_mid_crc", {16'h0, crc_o}, 0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_err", {31'h0, frm_err}, 1);
        idle(1);
        frame(1, 100, -1, -1);
        idle(3);
        chk("crc_post_rst", {16'h0, crc_o}, {16'h0, m_crc});
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
